// File: rtl/d_flip_flop_sync.sv
// rtl/d_flip_flop_sync.sv - D register with synchronous active-high reset and complementary outputs
module d_flip_flop_sync #(
   parameter int unsigned      WIDTH       = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_
);

   logic [WIDTH-1:0] state;

   // No initial value: state is undefined until the first sampling edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RESET_VALUE;
      end else begin
         state <= d;
      end
   end

   assign q  = state;
   assign q_ = ~state;

endmodule

// File: tb/tb_d_flip_flop_sync.sv
// tb/tb_d_flip_flop_sync.sv - self-checking bench for d_flip_flop_sync, 1-bit and 8-bit instances
module tb_d_flip_flop_sync;

   localparam logic [7:0] RV8 = 8'hA5;

   logic       clk = 1'b0;
   logic       reset;
   logic       d1;
   logic       q1, q1_;
   logic [7:0] d8;
   logic [7:0] q8, q8_;

   int checks = 0;
   int errors = 0;

   d_flip_flop_sync u_dut1 (
      .clk   (clk),
      .reset (reset),
      .d     (d1),
      .q     (q1),
      .q_    (q1_)
   );

   d_flip_flop_sync #(
      .WIDTH       (8),
      .RESET_VALUE (RV8)
   ) u_dut8 (
      .clk   (clk),
      .reset (reset),
      .d     (d8),
      .q     (q8),
      .q_    (q8_)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: the value held after an edge is RESET_VALUE if reset was high, else d.
   task automatic check_all(input string tag, input logic e1, input logic [7:0] e8);
      check({tag, ".q1"},  {7'd0, q1},  {7'd0, e1});
      check({tag, ".q1_"}, {7'd0, q1_}, {7'd0, ~e1});
      check({tag, ".q8"},  q8,  e8);
      check({tag, ".q8_"}, q8_, ~e8);
   endtask

   initial begin
      logic       m1;
      logic [7:0] m8;
      logic       r_n;
      logic       d1_n;
      logic [7:0] d8_n;

      reset = 1'b1;
      d1    = 1'b0;
      d8    = 8'h00;

      // t=6: reset applied at 5 ns edge
      @(posedge clk); #1;
      check_all("reset", 1'b0, RV8);

      // t=10: release with d8=3C
      #4;
      reset = 1'b0;
      d8    = 8'h3C;
      @(posedge clk); #1;
      check_all("release", 1'b0, 8'h3C);

      // Data toggle on falling edges; q must not move at the falling edge
      #4; d1 = 1'b1; #1;
      check("hold20", {7'd0, q1}, 8'd0);
      @(posedge clk); #1;
      check_all("cap25", 1'b1, 8'h3C);
      #4; d1 = 1'b0; #1;
      check("hold30", {7'd0, q1}, 8'd1);
      @(posedge clk); #1;
      check_all("cap35", 1'b0, 8'h3C);
      #4; d1 = 1'b1; #1;
      check("hold40", {7'd0, q1}, 8'd0);
      @(posedge clk); #1;
      check_all("cap45", 1'b1, 8'h3C);

      // Reset priority over data
      #4; reset = 1'b1; d1 = 1'b1; d8 = 8'hFF;
      @(posedge clk); #1;
      check_all("prio", 1'b0, RV8);
      #4; reset = 1'b0;
      @(posedge clk); #1;
      check_all("prio_rel", 1'b1, 8'hFF);

      // Reset pulse strictly between edges has no effect
      #2; reset = 1'b1;
      #2; reset = 1'b0;
      #1;
      check_all("noasync", 1'b1, 8'hFF);
      @(posedge clk); #1;
      check_all("noasync_edge", 1'b1, 8'hFF);

      m1 = 1'b1;
      m8 = 8'hFF;
      for (int i = 0; i < 200; i++) begin
         r_n  = ($urandom_range(0, 4) == 0);
         d1_n = 1'($urandom);
         d8_n = 8'($urandom);
         #4;
         reset = r_n;
         d1    = d1_n;
         d8    = d8_n;
         #1;
         check_all("rnd_hold", m1, m8);
         m1 = r_n ? 1'b0 : d1_n;
         m8 = r_n ? RV8  : d8_n;
         @(posedge clk); #1;
         check_all("rnd_cap", m1, m8);
         // Mid-cycle noise on inputs must not disturb the outputs
         d1    = 1'($urandom);
         d8    = 8'($urandom);
         reset = 1'($urandom);
         #1;
         check_all("rnd_glitch", m1, m8);
         reset = r_n;
         d1    = d1_n;
         d8    = d8_n;
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
